pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Generates hazard_stall, exe_stall, cond_exe_stall and int_flush, which drive the IF/ID register, plus the PC-hold and ID/EX/EX/MEM bubble controls.
- Sequences multi-cycle mult/div occupancy with an internal countdown.
- Arbitrates simultaneous exception, taken-branch, mult/div and load-use events with a fixed priority.

Parameters:
- MULT_CYCLES, 4, total EX stall cycles for a multiply (≥2).
- DIV_CYCLES, 32, total EX stall cycles for a divide (≥2).
- CNT_W, 6, countdown width; must hold DIV_CYCLES-1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- md_start  in  1  EX holds mult/div, level while instruction is in EX
- md_is_div  in  1  qualifies md_start: 1 = divide
- mem_ex  in  1  MEM stage raises exception/interrupt
- hazard_stall  out  1  load-use stall to IF/ID and PC
- exe_stall  out  1  mult/div stall to PC, IF/ID, ID/EX
- cond_exe_stall  out  1  clears IF/ID on taken branch
- int_flush  out  1  clears IF/ID, ID/EX, EX/MEM
- pc_stall  out  1  hold PC
- idex_bubble  out  1  load a bubble into ID/EX
- md_done  out  1  one-cycle pulse: mult/div result valid
- md_abort  out  1  one-cycle pulse: mult/div cancelled by exception

Behaviour:
- State: IDLE, MD_BUSY, EX_FLUSH; register cnt[CNT_W-1:0].
- Reset (resetn=0 at posedge): state<=IDLE, cnt<=0. All outputs are 0 in any cycle where resetn=0.
- Outputs are combinational from state, cnt and inputs.
- Priority, high to low: mem_ex/EX_FLUSH > ex_branch_taken > mult/div > load-use.
- int_flush:
  - Asserted when mem_ex=1 in any state, and for exactly one further cycle in EX_FLUSH.
  - mem_ex -> next state EX_FLUSH; EX_FLUSH -> IDLE unconditionally, or EX_FLUSH again if mem_ex=1.
  - While int_flush=1: hazard_stall=exe_stall=cond_exe_stall=pc_stall=idex_bubble=0, and md_start is ignored.
- mem_ex in MD_BUSY:
  - md_abort=1 that cycle, cnt<=0, state->EX_FLUSH.
  - md_done is never asserted for an aborted operation.
- Mult/div in IDLE, md_start=1 and no mem_ex:
  - exe_stall=1.
  - cnt<=(md_is_div ? DIV_CYCLES : MULT_CYCLES)-1.
  - state->MD_BUSY.
- MD_BUSY with cnt≠0: exe_stall=1, cnt decrements.
- MD_BUSY with cnt==0: exe_stall=0, md_done=1, state->IDLE.
- Net effect: exactly N stall cycles, then md_done on cycle N (cycle 0 = first md_start cycle). md_start is ignored in MD_BUSY.
- cond_exe_stall = ex_branch_taken & ~int_flush & ~exe_stall. During exe_stall the branch waits.
- Load-use hazard:
  - hazard_stall = ex_mem_read & (ex_rd≠0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - Masked by int_flush, cond_exe_stall and exe_stall.
- pc_stall = hazard_stall | exe_stall.
- idex_bubble = hazard_stall. exe_stall freezes ID/EX instead.
- Register $0 never creates a hazard.
- cnt never wraps: it decrements only in MD_BUSY with cnt≠0.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE=2'd0, MD_BUSY=2'd1, EX_FLUSH=2'd2), and MULT_CYCLES/DIV_CYCLES defaults for reuse by the mult/div unit.
- One natural sub-module, md_timer: loadable countdown producing busy/done, with a synchronous clear for abort.
- Load-use compare stays inline.

Test Plan:
- Reset held 3 cycles with md_start=1, mem_ex=1 -> all outputs 0. After release, state IDLE and a first md_start gives exe_stall immediately.
- Divide: md_start=1, md_is_div=1, DIV_CYCLES=32 -> exe_stall high cycles 0–31, md_done pulse on cycle 32 only, pc_stall tracks exe_stall.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1 -> hazard_stall=pc_stall=idex_bubble=1. Same with ex_rd=0 -> all 0.
- mem_ex at cycle 10 of a multiply-started-then-divide sequence -> md_abort=1 and int_flush=1 that cycle, int_flush=1 next cycle, no md_done, exe_stall=0 from the mem_ex cycle.
- ex_branch_taken=1 with concurrent load-use match -> cond_exe_stall=1, hazard_stall=0. Add mem_ex=1 -> only int_flush=1.
- Back-to-back mult (MULT_CYCLES=4): second md_start immediately after md_done -> exe_stall for 4 cycles again, no gap or overlap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller and the mult/div unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MD_BUSY  = 2'd1,
        EX_FLUSH = 2'd2
    } state_t;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

    function automatic int md_cycles(input logic is_div, input int mult_c, input int div_c);
        return is_div ? div_c : mult_c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stall/flush controls out.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       md_start;
    logic       md_is_div;
    logic       mem_ex;
    logic       hazard_stall;
    logic       exe_stall;
    logic       cond_exe_stall;
    logic       int_flush;
    logic       pc_stall;
    logic       idex_bubble;
    logic       md_done;
    logic       md_abort;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
               ex_branch_taken, md_start, md_is_div, mem_ex,
        input  hazard_stall, exe_stall, cond_exe_stall, int_flush,
               pc_stall, idex_bubble, md_done, md_abort
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
               ex_branch_taken, md_start, md_is_div, mem_ex,
        output hazard_stall, exe_stall, cond_exe_stall, int_flush,
               pc_stall, idex_bubble, md_done, md_abort
    );
endinterface

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// Loadable mult/div countdown; clear wins over load so an abort always empties it.
module md_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             clear,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clear)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: exception flush > taken branch > mult/div > load-use.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              resetn,
    pipe_hazard_ctrl_if.slave hif
);
    state_t           state;
    logic             timer_busy;
    logic             flush;
    logic             md_kick;
    logic             md_clear;
    logic             md_dec;
    logic             exe;
    logic             cond;
    logic             lu_match;
    logic             hazard;
    logic [CNT_W-1:0] load_val;

    always_comb begin
        flush    = resetn & (hif.mem_ex | (state == EX_FLUSH));
        md_kick  = resetn & ~flush & (state == IDLE) & hif.md_start;
        md_clear = resetn & hif.mem_ex & (state == MD_BUSY);
        md_dec   = resetn & ~flush & (state == MD_BUSY);
        exe      = md_kick | (md_dec & timer_busy);
        cond     = resetn & hif.ex_branch_taken & ~flush & ~exe;
        lu_match = hif.ex_mem_read & (hif.ex_rd != 5'd0) &
                   ((hif.id_use_rs & (hif.id_rs == hif.ex_rd)) |
                    (hif.id_use_rt & (hif.id_rt == hif.ex_rd)));
        hazard   = resetn & lu_match & ~flush & ~cond & ~exe;
        load_val = CNT_W'(md_cycles(hif.md_is_div, MULT_CYCLES, DIV_CYCLES) - 1);
    end

    always_comb begin
        hif.hazard_stall   = hazard;
        hif.exe_stall      = exe;
        hif.cond_exe_stall = cond;
        hif.int_flush      = flush;
        hif.pc_stall       = hazard | exe;
        hif.idex_bubble    = hazard;
        hif.md_done        = md_dec & ~timer_busy;
        hif.md_abort       = md_clear;
    end

    md_timer #(.CNT_W(CNT_W)) u_md_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (md_kick),
        .clear    (md_clear),
        .dec      (md_dec),
        .load_val (load_val),
        .busy     (timer_busy)
    );

    // An exception overrides everything, including an in-flight mult/div.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else if (hif.mem_ex)
            state <= EX_FLUSH;
        else begin
            case (state)
                IDLE:     if (hif.md_start) state <= MD_BUSY;
                MD_BUSY:  if (!timer_busy) state <= IDLE;
                EX_FLUSH: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule
